zynet_sequencer: RTL
====================

ZYNET_SEQUENCER -- requirements
Module: zynet_sequencer

Interface
REQ-001 Param NUM_SAMPLES, default 60: input samples per inference frame (>=2).
REQ-002 Param WATCHDOG_CYCLES, default 1024: max wait cycles per post-stream phase (watchdog build only).
REQ-003 Param FRAME_CNT_W, default 16: width of frame counter.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 reset_i  in  1  asynchronous, active-high reset.
REQ-006 start_i  in  1  begin a frame; honoured only in IDLE.
REQ-007 busy_o  out  1  high in every state except IDLE.
REQ-008 sample_valid_o  out  1  tx/rx sample offered to conv kernels.
REQ-009 sample_ready_i  in  1  conv kernels accept current sample.
REQ-010 sample_idx_o  out  $clog2(NUM_SAMPLES)  index of offered sample.
REQ-011 gap_done_i, hidden_done_i, output_done_i  in  1 each  completion pulses from GAP stage, hidden FC/BN/ReLU stage, output FC stage.
REQ-012 hidden_start_o, output_start_o  out  1 each  one-cycle launch pulses.
REQ-013 valid_o  out  1  network result available; yumi_i  in  1  consumer takes result.
REQ-014 frame_count_o  out  FRAME_CNT_W  completed frames; error_o  out  1  sticky watchdog error.

Function
REQ-015 FSM states: IDLE, STREAM, DRAIN, HIDDEN, OUTPUT, HOLD; all outputs registered.
REQ-016 IDLE: start_i=1 -> STREAM next cycle, sample_idx_o=0.
REQ-017 STREAM: sample_valid_o=1; each cycle with sample_valid_o&sample_ready_i increments sample_idx_o; handshake at idx NUM_SAMPLES-1 -> DRAIN, idx wraps to 0.
REQ-018 sample_idx_o holds while sample_ready_i=0; no sample dropped or repeated.
REQ-019 DRAIN: gap_done_i=1 -> HIDDEN; hidden_start_o=1 for exactly the first HIDDEN cycle.
REQ-020 HIDDEN: hidden_done_i=1 -> OUTPUT; output_start_o=1 for exactly the first OUTPUT cycle.
REQ-021 OUTPUT: output_done_i=1 -> HOLD.
REQ-022 HOLD: valid_o=1 until yumi_i=1; that cycle -> IDLE and frame_count_o increments (wraps at 2^FRAME_CNT_W).
REQ-023 Done inputs and yumi_i shall be ignored in any state not waiting for them; start_i ignored outside IDLE.
REQ-024 Done pulse arriving on the same cycle its phase is entered via launch pulse shall be honoured (single-cycle phase legal).
REQ-025 yumi_i and start_i together in HOLD: return to IDLE only; start_i not latched.

Reset
REQ-026 reset_i=1 asynchronously forces IDLE, sample_idx_o=0, frame_count_o=0, error_o=0, all valid/start/busy outputs 0.
REQ-027 Reset mid-frame abandons frame; no launch pulse or valid_o emitted after reset deasserts until a new start_i.

Configuration
REQ-028 Macro ZYNET_SEQ_WATCHDOG_EN defined: cycle counter cleared on entering DRAIN/HIDDEN/OUTPUT; reaching WATCHDOG_CYCLES without the awaited done sets error_o (sticky until reset) and forces IDLE, frame_count_o unchanged.
REQ-029 Macro undefined: no counter logic, error_o tied 0, phases wait indefinitely.

Structure
REQ-030 Package zynet_pkg holds the state enum typedef and shared WORD_SIZE/INT_BITS constants.
REQ-031 Watchdog counter is one sub-module seq_watchdog (clear, enable, expired), instantiated only under ZYNET_SEQ_WATCHDOG_EN.

Verification
REQ-032 NUM_SAMPLES=60, ready always 1, dones 3 cycles after each launch, yumi 2 cycles after valid -> 60 consecutive idx 0..59, one hidden_start_o, one output_start_o, frame_count_o=1.
REQ-033 sample_ready_i toggled every other cycle -> 60 accepted samples in 119-120 cycles, idx never skips/repeats.
REQ-034 gap_done_i pulsed during STREAM and start_i pulsed during HOLD -> both ignored, sequence unchanged.
REQ-035 reset_i asserted at sample 30, then new start_i -> outputs 0 immediately, next frame restarts at idx 0, frame_count_o=0 then 1.
REQ-036 Watchdog build, WATCHDOG_CYCLES=16, hidden_done_i never asserted -> error_o=1 at 16th HIDDEN cycle, state IDLE, busy_o=0; non-watchdog build same stimulus -> remains in HIDDEN, error_o=0.

Source files
------------

// File: rtl/zynet_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zynet_pkg
// Description : Shared types and constants for the ZyNet inference sequencer.
//               Holds the sequencer state encoding, the network fixed-point
//               word constants and a helper that identifies the phases that
//               wait on a downstream completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
package zynet_pkg;

    // Fixed-point format shared by the datapath stages.
    localparam int WORD_SIZE = 16;
    localparam int INT_BITS  = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_DRAIN  = 3'd2,
        S_HIDDEN = 3'd3,
        S_OUTPUT = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    // Phases that wait on a done pulse from a downstream stage.
    function automatic logic is_wait_phase(input state_t s);
        return (s == S_DRAIN) || (s == S_HIDDEN) || (s == S_OUTPUT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/zynet_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : zynet_sequencer_if
// Description : Control/handshake bundle between the sequencer and the rest
//               of the network. Suffixes are from the sequencer's viewpoint.
//   master : the sequencer (drives *_o, samples *_i)
//   slave  : the surrounding datapath / consumer
//   start_i, busy_o                  frame launch / activity flag
//   sample_valid_o, sample_ready_i,
//   sample_idx_o                     sample stream towards the conv kernels
//   gap_done_i, hidden_done_i,
//   output_done_i                    stage completion pulses
//   hidden_start_o, output_start_o   stage launch pulses
//   valid_o, yumi_i                  result handshake
//   frame_count_o, error_o           status
// Revision    : 1.0 - initial release
// ============================================================================
interface zynet_sequencer_if #(
    parameter int NUM_SAMPLES = 60,
    parameter int FRAME_CNT_W = 16
);
    localparam int IDX_W = $clog2(NUM_SAMPLES);

    logic                   start_i;
    logic                   busy_o;
    logic                   sample_valid_o;
    logic                   sample_ready_i;
    logic [IDX_W-1:0]       sample_idx_o;
    logic                   gap_done_i;
    logic                   hidden_done_i;
    logic                   output_done_i;
    logic                   hidden_start_o;
    logic                   output_start_o;
    logic                   valid_o;
    logic                   yumi_i;
    logic [FRAME_CNT_W-1:0] frame_count_o;
    logic                   error_o;

    modport master (
        input  start_i, sample_ready_i, gap_done_i, hidden_done_i,
               output_done_i, yumi_i,
        output busy_o, sample_valid_o, sample_idx_o, hidden_start_o,
               output_start_o, valid_o, frame_count_o, error_o
    );

    modport slave (
        output start_i, sample_ready_i, gap_done_i, hidden_done_i,
               output_done_i, yumi_i,
        input  busy_o, sample_valid_o, sample_idx_o, hidden_start_o,
               output_start_o, valid_o, frame_count_o, error_o
    );

endinterface
`default_nettype wire

// File: rtl/zynet_sequencer_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : seq_watchdog
// Description : Phase timeout counter. Cleared when a wait phase is entered,
//               counts while enabled, and flags expiry on the LIMIT-th
//               cycle of the phase. Only built with ZYNET_SEQ_WATCHDOG_EN.
//   clk_i, reset_i  clock / asynchronous active-high reset
//   clear_i         restart the count (priority over enable)
//   enable_i        count this cycle
//   expired_o       current cycle is the LIMIT-th cycle since clear
// Revision    : 1.0 - initial release
// ============================================================================
module seq_watchdog #(
    parameter int LIMIT = 1024
) (
    input  wire logic clk_i,
    input  wire logic reset_i,
    input  wire logic clear_i,
    input  wire logic enable_i,
    output logic      expired_o
);
    localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/zynet_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : zynet_sequencer
// Description : Frame sequencer for the ZyNet inference pipeline. Streams
//               NUM_SAMPLES sample indices to the conv kernels, then steps
//               through GAP drain, hidden layer and output layer, and holds
//               the result until the consumer takes it. All outputs are
//               registered.
//   clk_i, reset_i : clock / asynchronous active-high reset
//   bus            : zynet_sequencer_if.master control bundle
// Build option: ZYNET_SEQ_WATCHDOG_EN adds a per-phase timeout that aborts
//               the frame to IDLE and sets the sticky error_o.
// Revision    : 1.0 - initial release
// ============================================================================
module zynet_sequencer
    import zynet_pkg::*;
#(
    parameter int NUM_SAMPLES     = 60,
    parameter int WATCHDOG_CYCLES = 1024,
    parameter int FRAME_CNT_W     = 16
) (
    input  wire logic          clk_i,
    input  wire logic          reset_i,
    zynet_sequencer_if.master  bus
);
    localparam int IDX_W = $clog2(NUM_SAMPLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;
    logic                   busy_q, sample_valid_q, valid_q;
    logic                   hidden_start_q, output_start_q;
    logic                   wd_trip;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = S_STREAM;
                    idx_d   = '0;
                end
            end
            S_STREAM: begin
                // sample_valid_o is high throughout STREAM, so ready alone
                // completes the handshake.
                if (bus.sample_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.gap_done_i)  state_d = S_HIDDEN;
                else if (wd_trip)    state_d = S_IDLE;
            end
            S_HIDDEN: begin
                if (bus.hidden_done_i) state_d = S_OUTPUT;
                else if (wd_trip)      state_d = S_IDLE;
            end
            S_OUTPUT: begin
                if (bus.output_done_i) state_d = S_HOLD;
                else if (wd_trip)      state_d = S_IDLE;
            end
            S_HOLD: begin
                // start_i in the same cycle is deliberately not latched.
                if (bus.yumi_i) begin
                    state_d = S_IDLE;
                    frame_d = frame_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs; outputs are decoded from the next
    // state so they line up with the state they describe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            frame_q        <= '0;
            busy_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            valid_q        <= 1'b0;
            hidden_start_q <= 1'b0;
            output_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            frame_q        <= frame_d;
            busy_q         <= (state_d != S_IDLE);
            sample_valid_q <= (state_d == S_STREAM);
            valid_q        <= (state_d == S_HOLD);
            hidden_start_q <= (state_q == S_DRAIN)  && (state_d == S_HIDDEN);
            output_start_q <= (state_q == S_HIDDEN) && (state_d == S_OUTPUT);
        end
    end

    assign bus.busy_o         = busy_q;
    assign bus.sample_valid_o = sample_valid_q;
    assign bus.sample_idx_o   = idx_q;
    assign bus.valid_o        = valid_q;
    assign bus.hidden_start_o = hidden_start_q;
    assign bus.output_start_o = output_start_q;
    assign bus.frame_count_o  = frame_q;

`ifdef ZYNET_SEQ_WATCHDOG_EN
    logic wd_clear, wd_enable, wd_expired, error_q;

    assign wd_clear  = (state_d != state_q) && is_wait_phase(state_d);
    assign wd_enable = is_wait_phase(state_q);
    assign wd_trip   = wd_expired && wd_enable;

    seq_watchdog #(
        .LIMIT     (WATCHDOG_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    // A trip only turns into IDLE when the awaited done did not arrive.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            error_q <= 1'b0;
        end else if (wd_trip && (state_d == S_IDLE)) begin
            error_q <= 1'b1;
        end
    end

    assign bus.error_o = error_q;
`else
    logic [31:0] wd_unused_cfg;

    assign wd_unused_cfg = 32'(WATCHDOG_CYCLES);
    assign wd_trip       = 1'b0;
    assign bus.error_o   = 1'b0;
`endif

endmodule
`default_nettype wire
